imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader_byte_packer.sv | 43 ++++
 rtl/imem_loader.sv | 125 ++++++++++++
 tb/tb_imem_loader.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Contents:
//   state_t        - loader FSM states
//   HDR_BYTES      - length header size in bytes (big-endian word count)
//   BYTES_PER_WORD - bytes packed into each instruction word
//   word_addr()    - byte address of a word index relative to a base
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Word index scaled to a byte offset; no wrap check, the length limit
  // keeps the index inside the memory.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [15:0] index);
    return base + {14'd0, index, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Bus bundle between the loader, the host byte link and the instruction
// memory write port.
// Signals:
//   in_valid/in_data/in_ready - host byte stream, valid/ready handshake
//   wr_en/wr_addr/wr_data     - instruction memory write port
// Modports:
//   slave  - the loader (consumes bytes, drives the memory write port)
//   master - the host/memory side (drives bytes, observes writes)
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into 32-bit big-endian words.
// Ports:
//   clock, reset_n - system clock, asynchronous active-low reset
//   push           - accept in_byte this cycle
//   in_byte        - byte to shift in (first byte ends up in word[31:24])
//   clear          - discard any partial word
//   word           - shift register contents, a complete word when word_valid
//   word_valid     - one-cycle pulse in the cycle after the 4th byte is pushed
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        push,
  input  logic [7:0]  in_byte,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] count;

  // Bytes shift in from the bottom so the first byte of a word reaches the
  // top lane after four pushes; the counter wraps naturally every word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word       <= '0;
      count      <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      word       <= '0;
      count      <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= push && (count == 2'(BYTES_PER_WORD - 1));
      if (push) begin
        word  <= {word[23:0], in_byte};
        count <= count + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader on the write side of instruction memory. Reads a 16-bit
// big-endian word count followed by count*4 bytes, packs them into
// big-endian words and writes them to consecutive word addresses starting
// at BASE_ADDR, holding the CPU for the whole load.
// Ports:
//   clock, reset_n - system clock, asynchronous active-low reset
//   start          - one-cycle load request (honoured in IDLE, DONE, ERR)
//   bus            - host byte stream and memory write port (slave modport)
//   cpu_hold       - datapath stall request while a load is in progress
//   done           - one-cycle pulse on successful completion
//   error          - sticky length error, cleared by the next accepted start
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  localparam logic [15:0] DEPTH_LIMIT = 16'(DEPTH_WORDS);

  state_t      state;
  state_t      state_next;
  logic [15:0] len;
  logic [15:0] index;
  logic [15:0] len_full;
  logic        in_ready_q;
  logic        xfer;
  logic        start_accept;
  logic        push;
  logic [31:0] word;
  logic        word_valid;

  assign xfer         = bus.in_valid && in_ready_q;
  assign start_accept = start && (state == IDLE || state == DONE || state == ERR);
  assign push         = xfer && (state == DATA);
  assign len_full     = {len[15:8], bus.in_data};

  // The packer's pulse already lands one cycle after the 4th byte, so it
  // drives the write strobe directly; the address follows the word index,
  // which only moves at the end of a write cycle and so holds between writes.
  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = word_valid;
  assign bus.wr_data  = word;
  assign bus.wr_addr  = word_addr(BASE_ADDR, index);

  imem_loader_byte_packer u_byte_packer (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .in_byte    (bus.in_data),
    .clear      (start_accept),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DATA is left only after the write of the last word,
  // so DONE (and the cpu_hold release) follows the final memory write.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = LEN_HI;
      LEN_HI:  if (xfer) state_next = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (len_full == 16'd0) begin
            state_next = DONE;
          end else if (len_full > DEPTH_LIMIT) begin
            state_next = ERR;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA:    if (word_valid && (index + 16'd1 == len)) state_next = DONE;
      DONE:    if (start) state_next = LEN_HI;
      ERR:     if (start) state_next = LEN_HI;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with
  // the state they describe; error stays set for as long as ERR is held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_q <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      len        <= '0;
      index      <= '0;
    end else begin
      in_ready_q <= (state_next == LEN_HI) || (state_next == LEN_LO) ||
                    (state_next == DATA);
      cpu_hold   <= (state_next == LEN_HI) || (state_next == LEN_LO) ||
                    (state_next == DATA)   || (state_next == ERR);
      done       <= (state_next == DONE) && (state != DONE);
      error      <= (state_next == ERR);
      if (xfer && state == LEN_HI) len[15:8] <= bus.in_data;
      if (xfer && state == LEN_LO) len[7:0]  <= bus.in_data;
      if (start_accept) begin
        index <= '0;
      end else if (state == DATA && word_valid) begin
        index <= index + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: header parsing, word packing and
// addressing, zero and over-limit lengths, byte gaps, ignored start,
// asynchronous reset mid-load and a full-depth load.
module tb_imem_loader;

  logic clock = 1'b0;
  logic reset_n;
  logic start;
  logic cpu_hold;
  logic done;
  logic error;

  int passed      = 0;
  int total       = 0;
  int write_count = 0;
  int done_count  = 0;

  logic [31:0] addr_log [64];
  logic [31:0] data_log [64];

  imem_loader_if bus ();

  imem_loader #(
    .DEPTH_WORDS (64),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus.slave),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  // 100 MHz clock.
  always #5 clock = ~clock;

  // Write/done logger, sampled on the falling edge away from the updates.
  always @(negedge clock) begin
    if (bus.wr_en) begin
      if (write_count < 64) begin
        addr_log[write_count] = bus.wr_addr;
        data_log[write_count] = bus.wr_data;
      end
      write_count = write_count + 1;
    end
    if (done) done_count = done_count + 1;
  end

  // Overall time bound so a stuck design still terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total = total + 1;
    assert (observed === expected) passed = passed + 1;
    else $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Present one byte and hold it until it transfers (bounded wait).
  task automatic applyStimulus(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) break;
      @(negedge clock);
    end
    checkOutput("in_ready_wait", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_logs();
    write_count = 0;
    done_count  = 0;
  endtask

  task automatic check_reset_outputs(input string phase);
    checkOutput({phase, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    checkOutput({phase, "_wr_en"},    32'(bus.wr_en),    32'd0);
    checkOutput({phase, "_wr_addr"},  bus.wr_addr,       32'h0);
    checkOutput({phase, "_wr_data"},  bus.wr_data,       32'h0);
    checkOutput({phase, "_cpu_hold"}, 32'(cpu_hold),     32'd0);
    checkOutput({phase, "_done"},     32'(done),         32'd0);
    checkOutput({phase, "_error"},    32'(error),        32'd0);
  endtask

  initial begin
    logic [7:0] wb;

    reset_n      = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Two-word load.
    $display("[TB] two-word load");
    clear_logs();
    pulse_start();
    checkOutput("t1_hold_on",  32'(cpu_hold),     32'd1);
    checkOutput("t1_ready_on", 32'(bus.in_ready), 32'd1);
    checkOutput("t1_error",    32'(error),        32'd0);
    applyStimulus(8'h00); applyStimulus(8'h02);
    applyStimulus(8'h20); applyStimulus(8'h08); applyStimulus(8'h00); applyStimulus(8'h05);
    applyStimulus(8'h01); applyStimulus(8'h09); applyStimulus(8'h50); applyStimulus(8'h20);
    checkOutput("t1_wr_en_last", 32'(bus.wr_en), 32'd1);
    checkOutput("t1_wr_addr1",   bus.wr_addr,    32'h4);
    checkOutput("t1_wr_data1",   bus.wr_data,    32'h0109_5020);
    idle(1);
    checkOutput("t1_done",       32'(done),      32'd1);
    checkOutput("t1_hold_off",   32'(cpu_hold),  32'd0);
    idle(2);
    checkOutput("t1_writes",     32'(write_count), 32'd2);
    checkOutput("t1_addr0",      addr_log[0],      32'h0);
    checkOutput("t1_data0",      data_log[0],      32'h2008_0005);
    checkOutput("t1_addr1_log",  addr_log[1],      32'h4);
    checkOutput("t1_data1_log",  data_log[1],      32'h0109_5020);
    checkOutput("t1_done_count", 32'(done_count),  32'd1);
    checkOutput("t1_error_end",  32'(error),       32'd0);

    // Zero length: straight to DONE.
    $display("[TB] zero length");
    clear_logs();
    pulse_start();
    applyStimulus(8'h00); applyStimulus(8'h00);
    checkOutput("t2_done",     32'(done),         32'd1);
    checkOutput("t2_hold",     32'(cpu_hold),     32'd0);
    checkOutput("t2_ready",    32'(bus.in_ready), 32'd0);
    idle(1);
    checkOutput("t2_done_end", 32'(done),         32'd0);
    idle(1);
    checkOutput("t2_writes",   32'(write_count),  32'd0);
    checkOutput("t2_dones",    32'(done_count),   32'd1);

    // Over-limit length 65.
    $display("[TB] length above depth");
    clear_logs();
    pulse_start();
    applyStimulus(8'h00); applyStimulus(8'h41);
    checkOutput("t3_error",        32'(error),        32'd1);
    checkOutput("t3_hold",         32'(cpu_hold),     32'd1);
    checkOutput("t3_ready",        32'(bus.in_ready), 32'd0);
    idle(3);
    checkOutput("t3_error_sticky", 32'(error),        32'd1);
    checkOutput("t3_hold_sticky",  32'(cpu_hold),     32'd1);
    checkOutput("t3_writes",       32'(write_count),  32'd0);
    checkOutput("t3_dones",        32'(done_count),   32'd0);
    pulse_start();
    checkOutput("t3_error_clear",  32'(error),        32'd0);
    checkOutput("t3_hold_restart", 32'(cpu_hold),     32'd1);
    checkOutput("t3_ready_restart",32'(bus.in_ready), 32'd1);

    // One word with 3-cycle gaps between bytes (already in LEN_HI).
    $display("[TB] byte gaps");
    clear_logs();
    applyStimulus(8'h00); applyStimulus(8'h01);
    idle(3); applyStimulus(8'hAA);
    idle(3); applyStimulus(8'hBB);
    idle(3); applyStimulus(8'hCC);
    idle(3);
    checkOutput("t4_no_write_yet", 32'(write_count), 32'd0);
    checkOutput("t4_wr_en_idle",   32'(bus.wr_en),   32'd0);
    applyStimulus(8'hDD);
    checkOutput("t4_wr_en",   32'(bus.wr_en), 32'd1);
    checkOutput("t4_wr_addr", bus.wr_addr,    32'h0);
    checkOutput("t4_wr_data", bus.wr_data,    32'hAABB_CCDD);
    idle(1);
    checkOutput("t4_done",    32'(done),      32'd1);
    checkOutput("t4_wr_off",  32'(bus.wr_en), 32'd0);
    idle(1);
    checkOutput("t4_writes",  32'(write_count), 32'd1);

    // Valid bytes while not ready are not consumed.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    idle(3);
    checkOutput("ign_ready",  32'(bus.in_ready), 32'd0);
    checkOutput("ign_writes", 32'(write_count),  32'd1);
    checkOutput("ign_hold",   32'(cpu_hold),     32'd0);
    bus.in_valid = 1'b0;

    // start during DATA is ignored.
    $display("[TB] start during data");
    clear_logs();
    pulse_start();
    applyStimulus(8'h00); applyStimulus(8'h02);
    applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
    pulse_start();
    checkOutput("t5_hold",    32'(cpu_hold),     32'd1);
    checkOutput("t5_ready",   32'(bus.in_ready), 32'd1);
    checkOutput("t5_addr",    bus.wr_addr,       32'h4);
    applyStimulus(8'h55); applyStimulus(8'h66); applyStimulus(8'h77); applyStimulus(8'h88);
    idle(3);
    checkOutput("t5_writes",  32'(write_count), 32'd2);
    checkOutput("t5_addr0",   addr_log[0],      32'h0);
    checkOutput("t5_data0",   data_log[0],      32'h1122_3344);
    checkOutput("t5_addr1",   addr_log[1],      32'h4);
    checkOutput("t5_data1",   data_log[1],      32'h5566_7788);
    checkOutput("t5_dones",   32'(done_count),  32'd1);

    // Asynchronous reset after 6 data bytes of a 2-word load.
    $display("[TB] reset mid-load");
    clear_logs();
    pulse_start();
    applyStimulus(8'h00); applyStimulus(8'h02);
    applyStimulus(8'hA0); applyStimulus(8'hA1); applyStimulus(8'hA2); applyStimulus(8'hA3);
    applyStimulus(8'hA4); applyStimulus(8'hA5);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async");
    checkOutput("t6_writes", 32'(write_count), 32'd1);
    checkOutput("t6_addr0",  addr_log[0],      32'h0);
    checkOutput("t6_data0",  data_log[0],      32'hA0A1_A2A3);
    #2;
    reset_n = 1'b1;
    tick();
    pulse_start();
    applyStimulus(8'h00); applyStimulus(8'h01);
    applyStimulus(8'hDE); applyStimulus(8'hAD); applyStimulus(8'hBE); applyStimulus(8'hEF);
    checkOutput("t6_wr_en",    32'(bus.wr_en), 32'd1);
    checkOutput("t6_wr_addr",  bus.wr_addr,    32'h0);
    checkOutput("t6_wr_data",  bus.wr_data,    32'hDEAD_BEEF);
    idle(2);
    checkOutput("t6_writes2",  32'(write_count), 32'd2);
    checkOutput("t6_addr1",    addr_log[1],      32'h0);
    checkOutput("t6_data1",    data_log[1],      32'hDEAD_BEEF);
    checkOutput("t6_dones",    32'(done_count),  32'd1);

    // Full-depth load of exactly 64 words: word w = {w, C0, 5A, ~w}.
    $display("[TB] full depth");
    clear_logs();
    pulse_start();
    applyStimulus(8'h00); applyStimulus(8'h40);
    for (int w = 0; w < 64; w++) begin
      wb = 8'(w);
      applyStimulus(wb);
      applyStimulus(8'hC0);
      applyStimulus(8'h5A);
      applyStimulus(wb ^ 8'hFF);
    end
    idle(3);
    checkOutput("t7_writes",  32'(write_count), 32'd64);
    checkOutput("t7_addr0",   addr_log[0],      32'h0);
    checkOutput("t7_data0",   data_log[0],      32'h00C0_5AFF);
    checkOutput("t7_addr31",  addr_log[31],     32'h7C);
    checkOutput("t7_data31",  data_log[31],     32'h1FC0_5AE0);
    checkOutput("t7_addr63",  addr_log[63],     32'hFC);
    checkOutput("t7_data63",  data_log[63],     32'h3FC0_5AC0);
    checkOutput("t7_dones",   32'(done_count),  32'd1);
    checkOutput("t7_error",   32'(error),       32'd0);
    checkOutput("t7_hold",    32'(cpu_hold),    32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
